// File: rtl/binary_search_ctrl_pkg.sv
// rtl/binary_search_ctrl_pkg.sv - shared state encoding and default parameters for the binary search controller
package binary_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EVAL,
    DONE
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_CMP_LAT = 1;

endpackage

// File: rtl/binary_search_ctrl_if.sv
// rtl/binary_search_ctrl_if.sv - start/flag/result bundle between search controller and its user/comparator
interface binary_search_ctrl_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(WIDTH + 2);

  logic             start;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             cmp_eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] found;
  logic [PW-1:0]    probes;
  logic             error;

  modport master (
    input  start, cmp_lt, cmp_gt, cmp_eq,
    output guess, busy, done, found, probes, error
  );

  modport slave (
    output start, cmp_lt, cmp_gt, cmp_eq,
    input  guess, busy, done, found, probes, error
  );

endinterface

// File: rtl/binary_search_ctrl_bounds.sv
// rtl/binary_search_ctrl_bounds.sv - combinational bound update, next midpoint and flag sanity for one probe
module bsearch_bounds #(
  parameter int WIDTH = 4
) (
  input  logic             i_init,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_guess,
  input  logic             i_lt,
  input  logic             i_gt,
  input  logic             i_eq,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_mid,
  output logic             o_exhausted,
  output logic             o_bad_flags
);

  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_half;

  always_comb begin
    o_lo_nxt = i_lo;
    o_hi_nxt = i_hi;
    if (i_init) begin
      o_lo_nxt = '0;
      o_hi_nxt = '1;
    end else begin
      if (i_gt) o_lo_nxt = i_guess + WIDTH'(1);
      if (i_lt) o_hi_nxt = i_guess - WIDTH'(1);
    end
  end

  // Midpoint via the difference keeps the sum inside [lo,hi]; no carry out possible.
  assign w_diff = {1'b0, o_hi_nxt} - {1'b0, o_lo_nxt};
  assign w_half = WIDTH'(w_diff >> 1);
  assign o_mid  = o_lo_nxt + w_half;

  assign o_exhausted = (i_lt && (i_guess == i_lo)) || (i_gt && (i_guess == i_hi));
  assign o_bad_flags = !((i_lt ^ i_gt ^ i_eq) && !(i_lt && i_gt && i_eq));

endmodule

// File: rtl/binary_search_ctrl.sv
// rtl/binary_search_ctrl.sv - binary search initiator driving a registered magnitude comparator
module binary_search_ctrl
  import binary_search_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CMP_LAT = DEF_CMP_LAT
) (
  input  logic                  CLK,
  input  logic                  RST,
  binary_search_ctrl_if.master  bus
);

  localparam int PW  = $clog2(WIDTH + 2);
  localparam int WCW = (CMP_LAT > 2) ? $clog2(CMP_LAT - 1) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_guess;
  logic [WIDTH-1:0] r_found;
  logic [PW-1:0]    r_probes;
  logic [WCW-1:0]   r_wait;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_init;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_mid;
  logic             w_exhausted;
  logic             w_bad_flags;

  assign w_init = (r_state == IDLE) || (r_state == DONE);

  bsearch_bounds #(.WIDTH(WIDTH)) u_bounds (
    .i_init      (w_init),
    .i_lo        (r_lo),
    .i_hi        (r_hi),
    .i_guess     (r_guess),
    .i_lt        (bus.cmp_lt),
    .i_gt        (bus.cmp_gt),
    .i_eq        (bus.cmp_eq),
    .o_lo_nxt    (w_lo_nxt),
    .o_hi_nxt    (w_hi_nxt),
    .o_mid       (w_mid),
    .o_exhausted (w_exhausted),
    .o_bad_flags (w_bad_flags)
  );

  // guess is loaded on the edge entering ISSUE so the comparator sees it for the full probe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_guess  <= '0;
      r_found  <= '0;
      r_probes <= '0;
      r_wait   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_mid;
            r_probes <= PW'(1);
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait <= '0;
          if (CMP_LAT == 1) r_state <= EVAL;
          else              r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == WCW'(CMP_LAT - 2)) r_state <= EVAL;
          else                             r_wait  <= r_wait + WCW'(1);
        end
        EVAL: begin
          if (w_bad_flags || (!bus.cmp_eq && w_exhausted)) begin
            r_found <= '0;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else if (bus.cmp_eq) begin
            r_found <= r_guess;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_mid;
            r_probes <= r_probes + PW'(1);
            r_state  <= ISSUE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.guess  = r_guess;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.found  = r_found;
  assign bus.probes = r_probes;
  assign bus.error  = r_error;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// tb/tb_binary_search_ctrl.sv - bench pairing two controllers (CMP_LAT 1 and 3) with registered comparators
module tb_binary_search_ctrl;

  typedef struct packed {
    logic [3:0]  found;
    logic        chk_found;
    logic [2:0]  probes;
    logic        error;
    logic [7:0]  cycles;
    logic [2:0]  ng;
    logic [23:0] gv;
  } exp_t;

  logic       clk;
  logic       rst_v   [2];
  logic       start_v [2];
  logic [3:0] tgt_v   [2];
  logic       force_en[2];
  logic [2:0] force_val[2];

  logic       obs_busy [2];
  logic       obs_done [2];
  logic       obs_err  [2];
  logic [3:0] obs_guess[2];
  logic [3:0] obs_found[2];
  logic [2:0] obs_probes[2];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  binary_search_ctrl_if #(.WIDTH(4)) if1 ();
  binary_search_ctrl_if #(.WIDTH(4)) if3 ();

  binary_search_ctrl #(.WIDTH(4), .CMP_LAT(1)) u_dut1 (.CLK(clk), .RST(rst_v[0]), .bus(if1));
  binary_search_ctrl #(.WIDTH(4), .CMP_LAT(3)) u_dut3 (.CLK(clk), .RST(rst_v[1]), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] cmp(input logic [3:0] a, input logic [3:0] b);
    return {a < b, a > b, a == b};
  endfunction

  logic [2:0] p1;
  logic [2:0] p3 [3];
  always_ff @(posedge clk) begin
    p1    <= cmp(tgt_v[0], if1.guess);
    p3[0] <= cmp(tgt_v[1], if3.guess);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign {if1.cmp_lt, if1.cmp_gt, if1.cmp_eq} = force_en[0] ? force_val[0] : p1;
  assign {if3.cmp_lt, if3.cmp_gt, if3.cmp_eq} = force_en[1] ? force_val[1] : p3[2];
  assign if1.start = start_v[0];
  assign if3.start = start_v[1];

  assign obs_busy[0]   = if1.busy;   assign obs_busy[1]   = if3.busy;
  assign obs_done[0]   = if1.done;   assign obs_done[1]   = if3.done;
  assign obs_err[0]    = if1.error;  assign obs_err[1]    = if3.error;
  assign obs_guess[0]  = if1.guess;  assign obs_guess[1]  = if3.guess;
  assign obs_found[0]  = if1.found;  assign obs_found[1]  = if3.found;
  assign obs_probes[0] = if1.probes; assign obs_probes[1] = if3.probes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] f, input logic cf, input logic [2:0] p,
                              input logic e, input int cyc, input logic [2:0] ng,
                              input logic [23:0] gv);
    exp_t r;
    r.found = f; r.chk_found = cf; r.probes = p; r.error = e;
    r.cycles = 8'(cyc); r.ng = ng; r.gv = gv;
    return r;
  endfunction

  // Reference search: mode 0 honest comparator, 1 always-lt liar, 2 malformed flags.
  function automatic exp_t model(input logic [3:0] tgt, input int mode, input int lat);
    exp_t e;
    int lo, hi, g;
    e = '0; lo = 0; hi = 15;
    for (int i = 0; i < 6; i++) begin
      g = lo + ((hi - lo) >> 1);
      e.gv[i*4 +: 4] = 4'(g);
      e.ng++;
      e.probes++;
      if (mode == 2) begin e.error = 1'b1; e.chk_found = 1'b1; break; end
      if (mode == 0 && g == int'(tgt)) begin e.found = tgt; e.chk_found = 1'b1; break; end
      if (mode == 1 || int'(tgt) < g) begin
        if (g == lo) begin e.error = 1'b1; break; end
        hi = g - 1;
      end else begin
        if (g == hi) begin e.error = 1'b1; break; end
        lo = g + 1;
      end
    end
    e.cycles = 8'((1 + lat) * int'(e.probes));
    return e;
  endfunction

  task automatic run(input int k, input logic [3:0] tgt, input exp_t e, input int ignore_at);
    int    n, lat;
    logic [2:0]  ng;
    logic [23:0] gv;
    exp_t  x;
    string s;
    lat = (k == 0) ? 1 : 3;
    s = $sformatf("k%0d_t%0h", k, tgt);
    tgt_v[k] = tgt;
    sb.push_back(e);
    @(negedge clk); start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[k] = 1'b0;
    n = 0; ng = 3'd1; gv = '0;
    gv[3:0] = obs_guess[k];
    chk({s, "_busy"}, {31'b0, obs_busy[k]}, 32'd1);
    while (!obs_done[k] && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      start_v[k] = (n == ignore_at);
      if (!obs_done[k] && (n % (1 + lat)) == 0 && ng < 3'd6) begin
        gv[int'(ng)*4 +: 4] = obs_guess[k];
        ng++;
      end
    end
    start_v[k] = 1'b0;
    chk({s, "_done_seen"}, {31'b0, obs_done[k]}, 32'd1);
    x = sb.pop_front();
    if (x.chk_found) chk({s, "_found"}, 32'(obs_found[k]), 32'(x.found));
    chk({s, "_probes"}, 32'(obs_probes[k]), 32'(x.probes));
    chk({s, "_error"},  32'(obs_err[k]),    32'(x.error));
    chk({s, "_cycles"}, 32'(n),             32'(x.cycles));
    chk({s, "_idle"},   32'(obs_busy[k]),   32'd0);
    if (x.ng != 0) begin
      chk({s, "_nguess"}, 32'(ng), 32'(x.ng));
      chk({s, "_guesses"}, 32'(gv), 32'(x.gv));
    end
  endtask

  task automatic chk_zero(input int k, input string s);
    chk({s, "_busy"},   32'(obs_busy[k]),   32'd0);
    chk({s, "_done"},   32'(obs_done[k]),   32'd0);
    chk({s, "_error"},  32'(obs_err[k]),    32'd0);
    chk({s, "_guess"},  32'(obs_guess[k]),  32'd0);
    chk({s, "_found"},  32'(obs_found[k]),  32'd0);
    chk({s, "_probes"}, 32'(obs_probes[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; tgt_v[k] = '0;
      force_en[k] = 1'b0; force_val[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    chk_zero(0, "rst_k0");
    chk_zero(1, "rst_k1");

    // target 9 with a stray start pulse mid-search that must be ignored
    run(0, 4'h9, mk(4'h9, 1'b1, 3'd3, 1'b0, 6, 3'd3, 24'h0009B7), 2);
    repeat (3) @(negedge clk);
    chk("done_level_hold", 32'(obs_done[0]), 32'd1);

    run(0, 4'h0, mk(4'h0, 1'b1, 3'd4, 1'b0, 8,  3'd4, 24'h000137), -1);
    run(0, 4'hF, mk(4'hF, 1'b1, 3'd5, 1'b0, 10, 3'd5, 24'h0FEDB7), -1);

    for (int k = 0; k < 2; k++)
      for (int t = 0; t < 16; t++)
        run(k, 4'(t), model(4'(t), 0, (k == 0) ? 1 : 3), -1);

    force_en[0] = 1'b1; force_val[0] = 3'b000;
    run(0, 4'h5, mk(4'h0, 1'b1, 3'd1, 1'b1, 2, 3'd1, 24'h000007), -1);
    force_en[0] = 1'b0;
    run(0, 4'h6, model(4'h6, 0, 1), -1);
    force_en[1] = 1'b1; force_val[1] = 3'b110;
    run(1, 4'h5, mk(4'h0, 1'b1, 3'd1, 1'b1, 4, 3'd1, 24'h000007), -1);
    force_en[1] = 1'b0;
    run(1, 4'hA, model(4'hA, 0, 3), -1);

    // reset while waiting on the second probe of a CMP_LAT=3 search
    tgt_v[1] = 4'h5;
    @(negedge clk); start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[1] = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("mid_busy", 32'(obs_busy[1]), 32'd1);
    chk("mid_probes", 32'(obs_probes[1]), 32'd2);
    rst_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_v[1] = 1'b0;
    chk_zero(1, "abort_k1");
    run(1, 4'h5, model(4'h5, 0, 3), -1);

    force_en[0] = 1'b1; force_val[0] = 3'b100;
    run(0, 4'hC, mk(4'h0, 1'b0, 3'd4, 1'b1, 8, 3'd4, 24'h000137), -1);
    force_en[0] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
